machin_pi_engine: RTL

Parametrised multi-precision π engine: evaluates Machin's formula π = 16·atan(1/5) − 4·atan(1/239) over fixed-point numbers stored as L limbs of radix 10^D. It is the next generation of the design's π calculator. Over the previous calculator it adds:
- generic limb radix, length and term bound;
- a runtime term count;
- a start/busy/done handshake;
- early termination on a zero term;
- a clean synchronous readout port for the display path.

---
 rtl/machin_pi_if.sv | 16 +
 rtl/machin_pi_engine.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/machin_pi_if.sv
// machin_pi_if: start/done handshake and limb readout port of the pi engine
interface machin_pi_if #(
  parameter int TERM_W = 9,
  parameter int ADR_W = 6,
  parameter int LIMB_W = 10
);
  logic start;
  logic [TERM_W-1:0] n_terms;
  logic busy;
  logic done;
  logic [TERM_W-1:0] terms_done;
  logic [ADR_W-1:0] rd_addr;
  logic [LIMB_W-1:0] rd_data;
  modport master (output start, n_terms, rd_addr, input busy, done, terms_done, rd_data);
  modport slave (input start, n_terms, rd_addr, output busy, done, terms_done, rd_data);
endinterface

// File: rtl/machin_pi_engine.sv
// machin_pi_engine: multi-precision pi via Machin's formula over radix-10^D limbs
module machin_pi_engine #(
  parameter int L = 64,
  parameter int D = 3,
  parameter int LIMB_W = 10,
  parameter int MAX_TERMS = 511,
  parameter int TERM_W = 9,
  parameter int ADR_W = 6
) (
  input logic clk,
  input logic rst,
  machin_pi_if.slave bus
);
  localparam int R = 10 ** D;
  localparam int IW = $clog2(L);
  localparam int CW = $clog2(L + 2);
  localparam int VW = 2 * LIMB_W + 1;
  localparam int W1 = LIMB_W + 1;
  typedef enum logic [3:0] {IDLE, INIT, DIVA, DIVB1, DIVB2, SUB, DIVT, MERGE, FIN} state_t;
  state_t st;
  logic [LIMB_W-1:0] a [L];
  logic [LIMB_W-1:0] b [L];
  logic [LIMB_W-1:0] t [L];
  logic [LIMB_W-1:0] s [L];
  logic [CW-1:0] cnt;
  logic [TERM_W-1:0] k, n, terms_done;
  logic [LIMB_W-1:0] r, rd_data, src, div, q, rem;
  logic cy, nz, busy, done, valid, lv, last;
  logic [IW-1:0] fi, ri;
  logic [VW-1:0] val;
  logic [W1-1:0] dab, add, dst;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.terms_done = terms_done;
  assign bus.rd_data = rd_data;
  // Limb addressing plus the shared divide, add and subtract datapath of the current pass
  always_comb begin
    lv = 32'(cnt) < L;
    last = 32'(cnt) == L + 1;
    fi = cnt[IW-1:0];
    ri = IW'(L - 1) - fi;
    src = st == DIVA ? a[fi] : st == DIVT ? t[fi] : b[fi];
    div = st == DIVA ? LIMB_W'(25) : st == DIVT ? LIMB_W'(2 * 32'(k) - 1) : LIMB_W'(239);
    val = VW'(r) * VW'(R) + VW'(src);
    q = LIMB_W'(val / VW'(div));
    rem = LIMB_W'(val % VW'(div));
    dab = {1'b0, a[ri]} - {1'b0, b[ri]} - W1'(cy);
    add = {1'b0, s[ri]} + {1'b0, t[ri]} + W1'(cy);
    dst = {1'b0, s[ri]} - {1'b0, t[ri]} - W1'(cy);
  end
  // Pass sequencer: L limb cycles, two trailing pipeline cycles, then the next pass
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      k <= '0;
      n <= '0;
      r <= '0;
      cy <= 1'b0;
      nz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      terms_done <= '0;
      rd_data <= '0;
      valid <= 1'b0;
    end else begin
      done <= 1'b0;
      rd_data <= st == IDLE && !bus.start && valid && 32'(bus.rd_addr) < L ? s[bus.rd_addr[IW-1:0]] : '0;
      if (st != IDLE && st != FIN) cnt <= last ? '0 : cnt + CW'(1);
      case (st)
        IDLE: if (bus.start) begin
          n <= 32'(bus.n_terms) > MAX_TERMS ? TERM_W'(MAX_TERMS) : bus.n_terms;
          busy <= 1'b1;
          st <= INIT;
        end
        INIT: begin
          if (lv) begin
            a[fi] <= fi == '0 ? LIMB_W'(80) : '0;
            b[fi] <= fi == '0 ? LIMB_W'(956) : '0;
            t[fi] <= '0;
            s[fi] <= '0;
          end
          if (last) begin
            k <= '0;
            r <= '0;
            cy <= 1'b0;
            st <= n == '0 ? FIN : DIVA;
          end
        end
        DIVA, DIVB1, DIVB2, DIVT: begin
          if (lv) begin
            r <= rem;
            if (st == DIVA) a[fi] <= q;
            else if (st == DIVT) t[fi] <= q;
            else b[fi] <= q;
            if (q != '0) nz <= 1'b1;
          end
          if (last) begin
            r <= '0;
            if (st == DIVA) st <= DIVB1;
            else if (st == DIVB1) st <= DIVB2;
            else if (st == DIVB2) st <= SUB;
            else st <= MERGE;
          end
        end
        SUB: begin
          if (lv) begin
            t[ri] <= dab[LIMB_W] ? LIMB_W'(dab + W1'(R)) : dab[LIMB_W-1:0];
            cy <= dab[LIMB_W];
          end
          if (last) begin
            cy <= 1'b0;
            nz <= 1'b0;
            k <= k + TERM_W'(1);
            st <= DIVT;
          end
        end
        MERGE: begin
          if (lv) begin
            if (k[0]) begin
              s[ri] <= add >= W1'(R) ? LIMB_W'(add - W1'(R)) : add[LIMB_W-1:0];
              cy <= add >= W1'(R);
            end else begin
              s[ri] <= dst[LIMB_W] ? LIMB_W'(dst + W1'(R)) : dst[LIMB_W-1:0];
              cy <= dst[LIMB_W];
            end
          end
          if (last) begin
            cy <= 1'b0;
            st <= k == n || !nz ? FIN : DIVA;
          end
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          terms_done <= k;
          valid <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
